// File: rtl/glyph_line_renderer.sv
// glyph_line_renderer: stores a line of PS/2 set-2 scan codes and renders them
// as a scaled 5x7 font into a registered one-bit pixel mask at (ORIGIN_X, ORIGIN_Y).
// Optional blinking underline cursor enabled by defining GLYPH_CURSOR_EN.
module glyph_line_renderer #(
  parameter int ORIGIN_X     = 320,
  parameter int ORIGIN_Y     = 212,
  parameter int NUM_CHARS    = 8,
  parameter int SCALE_LOG2   = 1,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                           Pixelclock,
  input  logic                           reset,
  input  logic                           check,
  input  logic [7:0]                     character,
  input  logic [9:0]                     X,
  input  logic [9:0]                     Y,
  output logic                           mask,
  output logic [$clog2(NUM_CHARS+1)-1:0] count,
  output logic                           full
);

  localparam int CW = $clog2(NUM_CHARS + 1);
  localparam logic [15:0] LP_OX     = 16'(ORIGIN_X);
  localparam logic [15:0] LP_OY     = 16'(ORIGIN_Y);
  localparam logic [15:0] LP_TEXT_W = 16'(NUM_CHARS * (6 << SCALE_LOG2));
  localparam logic [15:0] LP_TEXT_H = 16'(7 << SCALE_LOG2);

  // Buffer stores a compact glyph id rather than the raw scan code.
  localparam logic [2:0] G_SPACE = 3'd0;
  localparam logic [2:0] G_F     = 3'd1;
  localparam logic [2:0] G_Q     = 3'd2;
  localparam logic [2:0] G_H     = 3'd3;
  localparam logic [2:0] G_X     = 3'd4;

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_BREAK = 1'b1} state_t;

  // Returns {supported, glyph id} for a scan code.
  function automatic logic [3:0] decode_code(input logic [7:0] code);
    logic [3:0] r;
    case (code)
      8'h2B:   r = {1'b1, G_F};
      8'h15:   r = {1'b1, G_Q};
      8'h33:   r = {1'b1, G_H};
      8'h22:   r = {1'b1, G_X};
      8'h29:   r = {1'b1, G_SPACE};
      default: r = {1'b0, G_SPACE};
    endcase
    return r;
  endfunction

  // Font ROM: 5-bit row (MSB = leftmost column); rows outside 0..6 are blank.
  function automatic logic [4:0] glyph_row(input logic [2:0] id, input logic [15:0] row);
    logic [4:0] r;
    r = 5'h00;
    if (row < 16'd7) begin
      case ({id, row[2:0]})
        {G_F, 3'd0}: r = 5'h1F;
        {G_F, 3'd1}: r = 5'h10;
        {G_F, 3'd2}: r = 5'h10;
        {G_F, 3'd3}: r = 5'h1E;
        {G_F, 3'd4}: r = 5'h10;
        {G_F, 3'd5}: r = 5'h10;
        {G_F, 3'd6}: r = 5'h10;
        {G_Q, 3'd0}: r = 5'h0E;
        {G_Q, 3'd1}: r = 5'h11;
        {G_Q, 3'd2}: r = 5'h11;
        {G_Q, 3'd3}: r = 5'h11;
        {G_Q, 3'd4}: r = 5'h15;
        {G_Q, 3'd5}: r = 5'h12;
        {G_Q, 3'd6}: r = 5'h0D;
        {G_H, 3'd0}: r = 5'h11;
        {G_H, 3'd1}: r = 5'h11;
        {G_H, 3'd2}: r = 5'h11;
        {G_H, 3'd3}: r = 5'h1F;
        {G_H, 3'd4}: r = 5'h11;
        {G_H, 3'd5}: r = 5'h11;
        {G_H, 3'd6}: r = 5'h11;
        {G_X, 3'd0}: r = 5'h11;
        {G_X, 3'd1}: r = 5'h11;
        {G_X, 3'd2}: r = 5'h0A;
        {G_X, 3'd3}: r = 5'h04;
        {G_X, 3'd4}: r = 5'h0A;
        {G_X, 3'd5}: r = 5'h11;
        {G_X, 3'd6}: r = 5'h11;
        default:     r = 5'h00;
      endcase
    end else begin
      r = 5'h00;
    end
    return r;
  endfunction

  // Selects one font column; column 5 (inter-character gap) is always dark.
  function automatic logic pick_col(input logic [4:0] bits, input logic [15:0] col);
    logic r;
    case (col)
      16'd0:   r = bits[4];
      16'd1:   r = bits[3];
      16'd2:   r = bits[2];
      16'd3:   r = bits[1];
      16'd4:   r = bits[0];
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  state_t          r_state;
  state_t          w_next_state;
  logic [CW-1:0]   r_count;
  logic [2:0]      r_buf [NUM_CHARS];
  logic            r_mask;
  logic [3:0]      w_dec;
  logic            w_wr_en;
  logic            w_bs_en;
  logic            w_clr_en;
  logic [15:0]     w_x16, w_y16, w_rx, w_ry, w_fx, w_fy, w_ci, w_col;
  logic            w_in_x, w_in_text_y, w_text_pix, w_cur_pix;
  logic [2:0]      w_cell_id;

  assign w_dec = decode_code(character);
  assign count = r_count;
  assign full  = (r_count == CW'(NUM_CHARS));
  assign mask  = r_mask;

  // FSM state register.
  always_ff @(posedge Pixelclock) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  // FSM next state: a 0xF0 prefix makes the following strobe get swallowed.
  always_comb begin
    w_next_state = r_state;
    if (check) begin
      case (r_state)
        ST_IDLE:  w_next_state = (character == 8'hF0) ? ST_BREAK : ST_IDLE;
        ST_BREAK: w_next_state = ST_IDLE;
        default:  w_next_state = ST_IDLE;
      endcase
    end else begin
      w_next_state = r_state;
    end
  end

  // FSM outputs: buffer edit commands, only from IDLE on a strobe.
  always_comb begin
    w_wr_en  = 1'b0;
    w_bs_en  = 1'b0;
    w_clr_en = 1'b0;
    if (check && (r_state == ST_IDLE)) begin
      if (w_dec[3] && !full)                                w_wr_en  = 1'b1;
      else if ((character == 8'h66) && (r_count != CW'(0))) w_bs_en  = 1'b1;
      else if (character == 8'h5A)                          w_clr_en = 1'b1;
      else                                                  w_wr_en  = 1'b0;
    end else begin
      w_wr_en = 1'b0;
    end
  end

  // Character count: append, backspace and clear-line.
  always_ff @(posedge Pixelclock) begin
    if (reset)         r_count <= CW'(0);
    else if (w_clr_en) r_count <= CW'(0);
    else if (w_wr_en)  r_count <= r_count + CW'(1);
    else if (w_bs_en)  r_count <= r_count - CW'(1);
    else               r_count <= r_count;
  end

  // Glyph buffer: entries at or beyond count are kept as space.
  always_ff @(posedge Pixelclock) begin
    for (int i = 0; i < NUM_CHARS; i++) begin
      if (reset || w_clr_en)                         r_buf[i] <= G_SPACE;
      else if (w_wr_en && (r_count == CW'(i)))       r_buf[i] <= w_dec[2:0];
      else if (w_bs_en && (r_count == CW'(i + 1)))   r_buf[i] <= G_SPACE;
      else                                           r_buf[i] <= r_buf[i];
    end
  end

  // Pixel-to-font coordinate mapping; range checks avoid wrap on negative offsets.
  always_comb begin
    w_x16       = {6'd0, X};
    w_y16       = {6'd0, Y};
    w_rx        = w_x16 - LP_OX;
    w_ry        = w_y16 - LP_OY;
    w_in_x      = (w_x16 >= LP_OX) && (w_rx < LP_TEXT_W);
    w_in_text_y = (w_y16 >= LP_OY) && (w_ry < LP_TEXT_H);
    w_fx        = w_rx >> SCALE_LOG2;
    w_fy        = w_ry >> SCALE_LOG2;
    w_ci        = w_fx / 16'd6;
    w_col       = w_fx % 16'd6;
  end

  // Buffer read for the addressed cell (pre-write contents).
  always_comb begin
    w_cell_id = G_SPACE;
    for (int i = 0; i < NUM_CHARS; i++) begin
      if (w_ci == 16'(i)) w_cell_id = r_buf[i];
      else                w_cell_id = w_cell_id;
    end
  end

  assign w_text_pix = w_in_x && w_in_text_y && pick_col(glyph_row(w_cell_id, w_fy), w_col);

`ifdef GLYPH_CURSOR_EN
  localparam logic [15:0] LP_CUR_Y0 = 16'(8 << SCALE_LOG2);
  localparam logic [15:0] LP_CUR_Y1 = 16'(9 << SCALE_LOG2);
  localparam logic [15:0] LP_BLINK  = 16'(BLINK_FRAMES);

  logic [15:0] r_frame_cnt;
  logic        r_phase_vis;

  // Frame counter and blink phase, stepped once per frame at pixel (0,0).
  always_ff @(posedge Pixelclock) begin
    if (reset) begin
      r_frame_cnt <= 16'd0;
      r_phase_vis <= 1'b1;
    end else if ((X == 10'd0) && (Y == 10'd0)) begin
      if (r_frame_cnt == (LP_BLINK - 16'd1)) begin
        r_frame_cnt <= 16'd0;
        r_phase_vis <= ~r_phase_vis;
      end else begin
        r_frame_cnt <= r_frame_cnt + 16'd1;
        r_phase_vis <= r_phase_vis;
      end
    end else begin
      r_frame_cnt <= r_frame_cnt;
      r_phase_vis <= r_phase_vis;
    end
  end

  assign w_cur_pix = r_phase_vis && !full && w_in_x && (w_y16 >= LP_OY) &&
                     (w_ry >= LP_CUR_Y0) && (w_ry < LP_CUR_Y1) &&
                     (w_ci == 16'(r_count)) && (w_col != 16'd5);
`else
  assign w_cur_pix = 1'b0;
`endif

  // Registered mask output: one cycle behind the sampled X,Y.
  always_ff @(posedge Pixelclock) begin
    if (reset) r_mask <= 1'b0;
    else       r_mask <= w_text_pix | w_cur_pix;
  end

endmodule

// File: tb/tb_glyph_line_renderer.sv
// Directed self-checking bench for glyph_line_renderer (default parameters).
module tb_glyph_line_renderer;

  logic       Pixelclock;
  logic       reset;
  logic       check;
  logic [7:0] character;
  logic [9:0] X;
  logic [9:0] Y;
  logic       mask;
  logic [3:0] count;
  logic       full;

  int n_checks = 0;
  int n_errors = 0;
  int lit;
  logic m;

  glyph_line_renderer dut (
    .Pixelclock(Pixelclock),
    .reset     (reset),
    .check     (check),
    .character (character),
    .X         (X),
    .Y         (Y),
    .mask      (mask),
    .count     (count),
    .full      (full)
  );

  initial Pixelclock = 1'b0;
  always #5 Pixelclock = ~Pixelclock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One-cycle check strobe carrying a scan code.
  task automatic send(input logic [7:0] code);
    @(negedge Pixelclock);
    check = 1'b1;
    character = code;
    @(negedge Pixelclock);
    check = 1'b0;
    character = 8'h00;
  endtask

  // Present a pixel, return the mask registered for it.
  task automatic sample(input int x, input int y, output logic mv);
    @(negedge Pixelclock);
    X = 10'(x);
    Y = 10'(y);
    @(negedge Pixelclock);
    mv = mask;
    X = 10'd700;
    Y = 10'd600;
  endtask

  task automatic pix(input string tag, input int x, input int y, input logic exp);
    logic mv;
    sample(x, y, mv);
    chk(tag, {31'd0, mv}, {31'd0, exp});
  endtask

  // Hold (0,0) for n cycles: n frame-start events.
  task automatic frames(input int n);
    @(negedge Pixelclock);
    X = 10'd0;
    Y = 10'd0;
    repeat (n) @(negedge Pixelclock);
    X = 10'd700;
    Y = 10'd600;
  endtask

  initial begin
    reset = 1'b1;
    check = 1'b0;
    character = 8'h00;
    X = 10'd700;
    Y = 10'd600;
    repeat (3) @(negedge Pixelclock);
    chk("reset_count", {28'd0, count}, 32'd0);
    chk("reset_full", {31'd0, full}, 32'd0);
    chk("reset_mask", {31'd0, mask}, 32'd0);
    reset = 1'b0;

    // Single F
    send(8'h2B);
    chk("f_count", {28'd0, count}, 32'd1);
    pix("f_320_212", 320, 212, 1'b1);
    pix("f_328_212", 328, 212, 1'b1);
    pix("f_gap_330", 330, 212, 1'b0);
    pix("f_322_214", 322, 214, 1'b0);
    pix("f_322_218", 322, 218, 1'b1);
    pix("left_of_origin", 318, 212, 1'b0);
    pix("above_origin", 320, 211, 1'b0);

    // F then H
    send(8'h33);
    chk("fh_count", {28'd0, count}, 32'd2);
    pix("h_332_218", 332, 218, 1'b1);
    pix("h_334_212", 334, 212, 1'b0);
    pix("h_340_212", 340, 212, 1'b1);
    pix("h_gap_342", 342, 212, 1'b0);
    pix("empty_344", 344, 212, 1'b0);

    // Clear, then nine supported codes (ninth dropped)
    send(8'h5A);
    chk("clr_count", {28'd0, count}, 32'd0);
    send(8'h2B); send(8'h15); send(8'h33); send(8'h22);
    send(8'h29); send(8'h2B); send(8'h15); send(8'h33);
    chk("eight_count", {28'd0, count}, 32'd8);
    chk("eight_full", {31'd0, full}, 32'd1);
    send(8'h22);
    chk("ninth_count", {28'd0, count}, 32'd8);
    chk("ninth_full", {31'd0, full}, 32'd1);
    pix("cell7_h_row3", 404, 218, 1'b1);
    pix("cell7_col4", 412, 212, 1'b1);
    pix("cell7_gap", 415, 212, 1'b0);
    pix("right_edge", 416, 212, 1'b0);
    pix("bottom_edge", 320, 226, 1'b0);
    send(8'h66);
    chk("bs_count", {28'd0, count}, 32'd7);
    chk("bs_full", {31'd0, full}, 32'd0);
    pix("cell6_q", 394, 212, 1'b1);
    lit = 0;
    for (int y = 212; y < 226; y++) begin
      for (int x = 404; x < 416; x++) begin
        sample(x, y, m);
        if (m) lit++;
      end
    end
    chk("cell7_blank", lit, 32'd0);

    // Break-code filtering
    send(8'h5A);
    send(8'h2B); send(8'hF0); send(8'h2B); send(8'h15);
    chk("brk_count", {28'd0, count}, 32'd2);
    pix("brk_q_col0", 332, 212, 1'b0);
    pix("brk_q_col1", 334, 212, 1'b1);
    send(8'hF0); send(8'h66);
    chk("brk_bs_count", {28'd0, count}, 32'd2);
    send(8'hF0); send(8'hF0); send(8'h2B);
    chk("brk_f0f0_count", {28'd0, count}, 32'd3);
    send(8'hE0);
    chk("e0_count", {28'd0, count}, 32'd3);

    // Enter with three stored
    send(8'h5A);
    chk("enter_count", {28'd0, count}, 32'd0);
    lit = 0;
    for (int y = 212; y < 226; y++) begin
      for (int x = 320; x < 416; x++) begin
        sample(x, y, m);
        if (m) lit++;
      end
    end
    chk("area_blank", lit, 32'd0);
    send(8'h66);
    chk("bs_empty_count", {28'd0, count}, 32'd0);

    // Reset coinciding with a check
    send(8'h2B);
    chk("pre_rst_count", {28'd0, count}, 32'd1);
    @(negedge Pixelclock);
    reset = 1'b1;
    check = 1'b1;
    character = 8'h33;
    @(negedge Pixelclock);
    reset = 1'b0;
    check = 1'b0;
    character = 8'h00;
    chk("rst_chk_count", {28'd0, count}, 32'd0);
    chk("rst_chk_full", {31'd0, full}, 32'd0);
    pix("rst_chk_cell0", 320, 212, 1'b0);

`ifdef GLYPH_CURSOR_EN
    pix("cur_vis0", 320, 228, 1'b1);
    frames(29);
    pix("cur_vis29", 320, 228, 1'b1);
    frames(1);
    pix("cur_hid30", 320, 228, 1'b0);
    frames(29);
    pix("cur_hid59", 320, 228, 1'b0);
    frames(1);
    pix("cur_vis60", 320, 228, 1'b1);
`else
    pix("no_cursor0", 320, 228, 1'b0);
    frames(30);
    pix("no_cursor30", 320, 228, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
